// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction queue between the fetch (IF) and decode (ID) stages. Holds up to
// DEPTH {pc, instruction} pairs so a decode stall does not lose fetched words,
// and presents the oldest pair to ID. A taken branch (flush) discards all
// contents. When empty, ID sees an all-zero bubble.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous reset, active-low
//   in_valid         IF presents a pair this cycle
//   in_ready         queue can accept a push (depends on count only)
//   in_pc            pc from IF
//   in_instruction   instruction word from IF
//   flush            discard all contents; overrides push, pop and freeze
//   freeze           ID stalled: hold the head
//   out_valid        head entry valid
//   out_pc           head pc (0 when !out_valid)
//   out_instruction  head instruction (0 when !out_valid)
//   count            occupied entries, 0..DEPTH
module if_fetch_queue #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [INSTR_W-1:0]       in_instruction,
  input  logic                     flush,
  input  logic                     freeze,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INSTR_W-1:0]       out_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;

  always_comb begin
    in_ready  = (count != FULL_CNT);
    out_valid = (count != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & ~freeze & ~flush;
    // Gating on out_valid keeps never-written slots off the outputs.
    out_pc          = out_valid ? pc_mem[rd_ptr]    : '0;
    out_instruction = out_valid ? instr_mem[rd_ptr] : '0;
  end

  // Storage is intentionally not reset; it is only observable when valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instruction;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instruction;
  logic        flush;
  logic        freeze;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [2:0]  count;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;

  if_fetch_queue #(
    .ADDR_W (32),
    .INSTR_W(32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instruction (in_instruction),
    .flush          (flush),
    .freeze         (freeze),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instruction(out_instruction),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compares the presented head against the expected queue, then
  // retires the head when the cycle's controls imply a pop or flush.
  always @(negedge clk) begin
    int n;
    if (!rst) begin
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_ready", 64'(in_ready), 64'(1));
      chk("rst_pc", 64'(out_pc), 64'(0));
      chk("rst_ins", 64'(out_instruction), 64'(0));
      sb.delete();
    end else begin
      n = sb.size();
      chk("count", 64'(count), 64'(n));
      chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(n != 0));
      if (n != 0) begin
        chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
        chk("out_ins", 64'(out_instruction), 64'(sb[0].ins));
      end else begin
        chk("bubble_pc", 64'(out_pc), 64'(0));
        chk("bubble_ins", 64'(out_instruction), 64'(0));
      end
      if (flush) sb.delete();
      else if (n != 0 && !freeze) void'(sb.pop_front());
    end
  end

  // One clock of stimulus. Acceptance is decided from the expected occupancy
  // at issue time; the accepted pair is queued after the monitor has seen
  // this cycle, so it becomes the expectation from the next cycle on.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic fr, input logic fl, output bit acc);
    @(posedge clk); #1;
    in_valid       = v;
    in_pc          = pc;
    in_instruction = ins;
    freeze         = fr;
    flush          = fl;
    acc = v && !fl && (sb.size() < DEPTH);
    @(negedge clk); #1;
    if (acc) sb.push_back('{pc, ins});
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a);
  endtask

  task automatic async_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    freeze   = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'(0));
    chk("async_valid", 64'(out_valid), 64'(0));
    chk("async_ready", 64'(in_ready), 64'(1));
    chk("async_pc", 64'(out_pc), 64'(0));
    chk("async_ins", 64'(out_instruction), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    bit a;
    int tries;
    rst = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_instruction = '0;
    flush = 1'b0;
    freeze = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Straight-through pushes with ID running.
    for (int i = 1; i <= 3; i++)
      cyc(1'b1, 32'(4 * i), 32'hE3A0_1001 + 32'(i - 1) * 32'h1001, 1'b0, 1'b0, a);
    idle(2);

    // Fill while frozen, fifth word refused, then drains in order.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, a);
    tries = 0;
    a = 1'b0;
    while (!a && tries < 10) begin
      cyc(1'b1, 32'h110, 32'hA000_0004, 1'b0, 1'b0, a);
      tries++;
    end
    total++;
    if (!a) begin
      bad++;
      $display("FAIL fifth_accept: got not accepted expected accepted within 10 cycles");
    end
    idle(6);

    // Flush on a full queue with a word offered in the same cycle.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0, a);
    cyc(1'b1, 32'hDEAD_BEEC, 32'hDEAD_BEEF, 1'b1, 1'b1, a);
    idle(3);

    // Steady push and pop across the pointer wrap.
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0, a);
    for (int i = 2; i < 12; i++)
      cyc(1'b1, 32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0, a);
    idle(4);

    // Asynchronous reset with three entries held.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h400 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b1, 1'b0, a);
    async_reset();
    cyc(1'b1, 32'h500, 32'hE000_0000, 1'b0, 1'b0, a);
    idle(2);

    // Empty queue with freeze toggling.
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 32'h0, 32'h0, 1'(i % 2), 1'b0, a);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cyc(1'($urandom_range(0, 9) < 7), $urandom, $urandom,
            1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 29) == 0), a);
      end
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
